// File: rtl/tsc_reader_if.sv
// TSC capture link: one-cycle request out, byte stream back.
// The reader is the master end; the TSC core is the slave.
interface tsc_reader_if;
  logic       req;
  logic       rdy;
  logic [7:0] dat;

  modport master (
    output req,
    input  rdy,
    input  dat
  );

  modport slave (
    input  req,
    output rdy,
    output dat
  );
endinterface

// File: rtl/tsc_reader.sv
// Host-side TSC transfer receiver: requests a capture, collects the
// 32-bit trigger time plus NSAMP sample bytes into a readable buffer.
module tsc_reader #(
  parameter int NSAMP   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  tsc_reader_if.master  lnk,
  input  logic          fetch,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   timestamp,
  output logic [AW:0]   count,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_RX_TS  = 3'd3,
    S_RX_DAT = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(NSAMP - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] to_q, to_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] ts_q, ts_d;
  logic [AW:0] count_q, count_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        we;

  logic [7:0]  mem_q [NSAMP];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_d     = to_q;
    shadow_d = shadow_q;
    ts_d     = ts_q;
    count_d  = count_q;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (fetch) begin
          state_d = S_REQ;
          count_d = '0;
          idx_d   = '0;
          to_d    = '0;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT, S_RX_TS, S_RX_DAT: begin
        if (lnk.rdy) begin
          to_d = '0;
          unique case (state_q)
            S_WAIT: begin
              shadow_d = {shadow_q[23:0], lnk.dat};
              idx_d    = 2'd1;
              state_d  = S_RX_TS;
            end
            S_RX_TS: begin
              shadow_d = {shadow_q[23:0], lnk.dat};
              idx_d    = idx_q + 2'd1;
              if (idx_q == 2'd3) state_d = S_RX_DAT;
            end
            default: begin
              we      = 1'b1;
              count_d = count_q + 1'b1;
              // commit on entry so timestamp moves with done
              if (count_q == CNT_LAST) begin
                state_d = S_DONE;
                ts_d    = shadow_q;
              end
            end
          endcase
        end else if (to_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      to_q      <= '0;
      shadow_q  <= '0;
      ts_q      <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      shadow_q  <= shadow_d;
      ts_q      <= ts_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // buffer keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) mem_q[count_q[AW-1:0]] <= lnk.dat;
  end

  assign rd_data_d = mem_q[rd_addr];

  assign lnk.req   = (state_q == S_REQ);
  assign state     = state_q;
  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                     (state_q == S_RX_TS) || (state_q == S_RX_DAT);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign timestamp = ts_q;
  assign count     = count_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_tsc_reader.sv
// Scoreboard bench for tsc_reader: stimulus pushes expected transfers
// and read data; a negedge monitor pops and compares.
module tb_tsc_reader;
  localparam int NSAMP   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [2:0]    state;
  logic          busy, done, err;
  logic [31:0]   timestamp;
  logic [AW:0]   count;
  logic [7:0]    rd_data;

  tsc_reader_if lnk ();

  tsc_reader #(.NSAMP(NSAMP), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .lnk(lnk), .fetch(fetch),
    .state(state), .busy(busy), .done(done), .err(err),
    .timestamp(timestamp), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ts;
    int          cnt;
    int          edge_n;
  } exp_t;

  exp_t        done_q[$];
  logic [7:0]  rd_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;
  int          req_cnt = 0;
  bit          rd_pend = 1'b0;
  bit          rd_pend_d = 1'b0;
  logic [7:0]  mdl_mem [NSAMP];
  logic [31:0] mdl_ts = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt  <= edge_cnt + 1;
    rd_pend_d <= rd_pend;
  end

  always @(negedge clk) begin
    if (lnk.req) req_cnt++;
    if (done) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want none");
      end else begin
        e = done_q.pop_front();
        chk("done_ts", timestamp, e.ts);
        chk("done_count", 32'(count), e.cnt);
        if (e.edge_n != 0) chk("done_edge", edge_cnt + 1, e.edge_n);
      end
    end
    if (rd_pend_d) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_underflow: got read want none");
      end else begin
        chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_req"}, 32'(lnk.req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ts"}, timestamp, 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_rd"}, 32'(rd_data), 0);
  endtask

  task automatic put(input logic [7:0] b, input int gap, input bit spam);
    int g;
    lnk.rdy = 1'b1;
    lnk.dat = b;
    fetch   = spam;
    tick();
    lnk.rdy = 1'b0;
    fetch   = 1'b0;
    lnk.dat = 8'($urandom);
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) tick();
  endtask

  task automatic start(output int n);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    n = edge_cnt;
    chk("req_high", 32'(lnk.req), 1);
    chk("err_clr", 32'(err), 0);
    tick();
  endtask

  task automatic readback();
    for (int i = 0; i < NSAMP; i++) begin
      rd_addr = AW'(i);
      rd_pend = 1'b1;
      rd_q.push_back(mdl_mem[i]);
      tick();
    end
    rd_pend = 1'b0;
    tick();
    tick();
    chk("rd_drained", rd_q.size(), 0);
  endtask

  task automatic xfer(input int mode, input int nsent, input int gap,
                      input bit spam, input bit timed);
    logic [31:0] ts;
    logic [7:0]  s[$];
    int          r0, n;
    ts = (mode == 0) ? 32'h12345678 : $urandom;
    for (int i = 0; i < nsent; i++)
      s.push_back((mode == 0) ? 8'(i) : 8'($urandom));
    for (int i = 0; i < NSAMP; i++) mdl_mem[i] = s[i];
    mdl_ts = ts;
    r0 = req_cnt;
    start(n);
    done_q.push_back('{ts, NSAMP, timed ? n + 6 + NSAMP : 0});
    for (int b = 0; b < 4; b++) put(ts[31-8*b -: 8], gap, spam);
    for (int i = 0; i < nsent; i++) put(s[i], gap, spam && i < NSAMP);
    repeat (3) tick();
    chk("idle_after", 32'(busy), 0);
    chk("req_pulses", req_cnt - r0, 1);
    chk("done_drained", done_q.size(), 0);
    chk("count_hold", 32'(count), NSAMP);
    readback();
  endtask

  initial begin
    int n;
    lnk.rdy = 1'b0;
    lnk.dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b1;
    tick();

    xfer(0, NSAMP, 0, 1'b0, 1'b1);
    xfer(0, NSAMP, 3, 1'b0, 1'b0);

    // timeout after two timestamp bytes
    start(n);
    put(8'hAB, 0, 1'b0);
    put(8'hCD, 0, 1'b0);
    repeat (TIMEOUT - 1) tick();
    chk("pre_timeout_state", 32'(state), 3);
    tick();
    chk("to_state", 32'(state), 6);
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_ts", timestamp, mdl_ts);
    lnk.rdy = 1'b1;
    repeat (3) tick();
    lnk.rdy = 1'b0;
    chk("err_hold", 32'(state), 6);
    xfer(1, NSAMP, 0, 1'b0, 1'b1);

    xfer(1, NSAMP, 0, 1'b1, 1'b1);
    repeat (3) xfer(1, NSAMP, -1, 1'b0, 1'b0);

    // asynchronous reset in RX_DAT with count=10
    start(n);
    for (int b = 0; b < 4; b++) put(8'($urandom), 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mdl_mem[i] = 8'($urandom);
      put(mdl_mem[i], 0, 1'b0);
    end
    chk("mid_count", 32'(count), 10);
    reset = 1'b0;
    #1;
    chk_reset("mid");
    mdl_ts = '0;
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_ts", timestamp, 0);
    xfer(1, NSAMP, 0, 1'b0, 1'b1);

    xfer(1, NSAMP + 8, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tsc_reader.md
# tsc_reader

Host-side receiver for the TSC capture-transfer protocol. On a host `fetch` pulse it issues a one-cycle `req` to the TSC, then accepts bytes qualified by `rdy`: a 32-bit trigger timestamp (MSB first) followed by `NSAMP` sample bytes. Samples go into an internal buffer with a registered random-access read port. A committed timestamp is presented to the host. It sits between the TSC capture core and the host/readout logic, forming the consuming end of the `req`/`rdy`/`dat` link.

## Interface
- `NSAMP`, 32: number of sample bytes per transfer (power of two, 2..256).
- `AW`, 5: buffer address width; must satisfy 2^AW == NSAMP.
- `TIMEOUT`, 255: maximum consecutive `rdy`-low cycles allowed in WAIT/RX states before error (1..65535).
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset asserted).
- `fetch`, in, 1: host request for a transfer; sampled on each rising edge.
- `req`, out, 1: request to the TSC.
- `rdy`, in, 1: TSC byte-valid strobe.
- `dat`, in, 8: TSC data byte; valid when `rdy`=1.
- `state`, out, 3: current FSM state encoding.
- `busy`, out, 1: high in REQ, WAIT, RX_TS, RX_DAT.
- `done`, out, 1: one-cycle pulse when a transfer completes.
- `err`, out, 1: timeout flag.
- `timestamp`, out, 32: last committed trigger time.
- `count`, out, AW+1: sample bytes received in the current or last transfer.
- `rd_addr`, in, AW: buffer read address.
- `rd_data`, out, 8: buffer read data.

## Operation
- State encodings: IDLE=0, REQ=1, WAIT=2, RX_TS=3, RX_DAT=4, DONE=5, ERR=6.
- IDLE: if `fetch`=1, go to REQ. Clear `count`, the byte index, and the timeout counter.
- REQ: `req`=1 for exactly this one cycle, then go to WAIT.
- WAIT: the first `rdy`=1 cycle loads `dat` into shadow timestamp bits [31:24] and moves to RX_TS with byte index 1.
- RX_TS: each `rdy`=1 cycle loads the next shadow byte ([23:16], [15:8], [7:0]). After the 4th byte, go to RX_DAT.
- RX_DAT: each `rdy`=1 cycle writes `dat` to buffer[`count`] and increments `count`. The cycle that writes byte NSAMP-1 moves to DONE.
- DONE: copy the shadow to `timestamp`, assert `done` for one cycle, return to IDLE.
- Gaps: `rdy`=0 cycles in WAIT/RX_TS/RX_DAT are allowed. Each `rdy`=0 cycle increments the timeout counter, and any accepted byte clears it.
- Timeout: when the counter reaches TIMEOUT, go to ERR. `timestamp` is not updated, and buffer contents are retained as partially written.
- ERR: `err`=1 (held). `fetch`=1 clears `err` and goes to REQ. No other exit except reset.
- `fetch` is ignored while `busy`=1 or in DONE.
- `rdy`=1 in IDLE, REQ, DONE, or ERR is ignored: no write and no state change.
- Bytes arriving after the NSAMP-th (TSC overrun) are ignored.
- `count` holds its final value until the next REQ.
- Reset values: `state`=IDLE, `req`=0, `busy`=0, `done`=0, `err`=0, `timestamp`=0, `count`=0, `rd_data`=0. Buffer contents are not reset.
- Reset mid-transfer: everything returns to the reset values immediately (asynchronous). A partially received timestamp is discarded.

## Timing
- The `fetch` at edge N puts the FSM in REQ after N, so `req` is high from N to N+1.
- The earliest accepted byte is the `rdy`=1 sampled at edge N+2.
- With back-to-back `rdy`, the last sample is accepted at edge N+2+3+NSAMP. DONE is entered there, `done` is high for the following cycle, and IDLE is reached one edge later.
- `timestamp` changes on the same edge that asserts `done`.
- `rd_data` is registered: `rd_data` = buffer[`rd_addr`] one cycle after `rd_addr` is presented.
- Read-during-write to the same address returns the old data.
- Timeout: ERR is entered on the edge where the TIMEOUT-th consecutive `rdy`=0 is sampled.

## Test plan
- Reset, then `fetch` pulse, then TSC streams `12 34 56 78` followed by samples 0x00..0x1F back-to-back -> `req` high for 1 cycle. `done` pulses at fetch+38 edges, `timestamp`=0x12345678, `count`=32, reading addresses 0..31 returns 0x00..0x1F.
- Same stream with `rdy` dropped for 3 cycles after every byte -> identical final `timestamp`/buffer and one `done` pulse.
- `fetch`, 2 timestamp bytes, then `rdy` held low for TIMEOUT cycles -> `err`=1, `state`=6, `timestamp` keeps its previous value. A new `fetch` clears `err` and `req` pulses.
- `fetch` pulsed repeatedly during an active transfer -> no extra `req`, and the transfer completes normally.
- `reset`=0 asserted in RX_DAT at `count`=10 -> all outputs return to reset values asynchronously. A following full transfer succeeds.
- 40 sample bytes sent back-to-back -> only the first 32 are stored, `count`=32, and `done` pulses exactly once.
